// File: rtl/scan_decider_pkg.sv
// Shared types and defaults for the DPLL decision scanner.
// Holds the decision-order entry layout and the scanner FSM state encoding.
package scan_decider_pkg;

  localparam int unsigned MAX_VARS       = 8;
  localparam int unsigned MAX_VARS_BITS  = 3;
  localparam int unsigned SCAN_DEC_WIDTH = 4;

  typedef struct packed {
    logic [MAX_VARS_BITS-1:0] var_idx;
    logic                     val;
  } config_var;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    HOLD
  } scan_dec_state_t;

endpackage

// File: rtl/scan_decider_first_free_window.sv
// Priority encoder over one scan window of the decision order.
// Reports the lowest window offset whose variable is still unassigned.
module first_free_window #(
  parameter int unsigned NUM_VARS   = 8,
  parameter int unsigned VAR_BITS   = 3,
  parameter int unsigned SCAN_WIDTH = 4,
  parameter int unsigned OFF_BITS   = 2
) (
  input  logic [VAR_BITS-1:0] i_var_idx [NUM_VARS],
  input  logic [NUM_VARS-1:0] i_assigned,
  input  logic [VAR_BITS:0]   i_base,
  output logic                o_found,
  output logic [OFF_BITS-1:0] o_offset
);

  localparam int unsigned EW = VAR_BITS + 2;

  always_comb begin
    logic [EW-1:0] w_pos;
    logic          w_found;
    w_found  = 1'b0;
    o_offset = '0;
    w_pos    = '0;
    for (int unsigned k = 0; k < SCAN_WIDTH; k++) begin
      w_pos = EW'(i_base) + EW'(k);
      // Positions past the end of the order list never match.
      if (!w_found && (w_pos < EW'(NUM_VARS))) begin
        if (!i_assigned[i_var_idx[w_pos[VAR_BITS-1:0]]]) begin
          w_found  = 1'b1;
          o_offset = OFF_BITS'(k);
        end
      end
    end
    o_found = w_found;
  end

endmodule

// File: rtl/scan_decider.sv
// DPLL decision unit: walks the decision order from a pointer, issues the next
// unassigned variable over a valid/ack handshake, and supports backtrack with flip.
module scan_decider
  import scan_decider_pkg::*;
#(
  parameter int unsigned NUM_VARS   = MAX_VARS,
  parameter int unsigned VAR_BITS   = MAX_VARS_BITS,
  parameter int unsigned SCAN_WIDTH = SCAN_DEC_WIDTH
) (
  input  logic                clock,
  input  logic                reset,
  input  config_var           dec_config [NUM_VARS],
  input  logic [NUM_VARS-1:0] assigned,
  input  logic                req,
  input  logic                dec_ack,
  input  logic                bt_valid,
  // One extra bit so the end-of-order position can be commanded directly.
  input  logic [VAR_BITS:0]   bt_dec_idx,
  input  logic                bt_flip,
  output logic                dec_valid,
  output logic [VAR_BITS-1:0] dec_idx_out,
  output logic [VAR_BITS-1:0] var_idx_out,
  output logic                val_out,
  output logic                all_assigned,
  output logic                busy
);

  localparam int unsigned PW       = VAR_BITS + 1;
  localparam int unsigned EW       = VAR_BITS + 2;
  localparam int unsigned OFF_BITS = (SCAN_WIDTH > 1) ? $clog2(SCAN_WIDTH) : 1;

  scan_dec_state_t     r_state, w_state;
  logic [PW-1:0]       r_ptr, w_ptr;
  logic                r_flip_pend, w_flip_pend;
  logic [PW-1:0]       r_flip_idx, w_flip_idx;
  logic                w_dec_valid, w_val, w_all, w_busy, w_flip_hit;
  logic [VAR_BITS-1:0] w_dec_idx, w_var_idx;
  logic [VAR_BITS-1:0] w_cfg_var [NUM_VARS];
  logic                w_found;
  logic [OFF_BITS-1:0] w_offset;
  logic [EW-1:0]       w_hit, w_adv;
  config_var           w_cfg;

  always_comb begin
    for (int unsigned i = 0; i < NUM_VARS; i++) begin
      w_cfg_var[i] = VAR_BITS'(dec_config[i].var_idx);
    end
  end

  first_free_window #(
    .NUM_VARS  (NUM_VARS),
    .VAR_BITS  (VAR_BITS),
    .SCAN_WIDTH(SCAN_WIDTH),
    .OFF_BITS  (OFF_BITS)
  ) u_window (
    .i_var_idx (w_cfg_var),
    .i_assigned(assigned),
    .i_base    (r_ptr),
    .o_found   (w_found),
    .o_offset  (w_offset)
  );

  always_comb begin
    w_state     = r_state;
    w_ptr       = r_ptr;
    w_flip_pend = r_flip_pend;
    w_flip_idx  = r_flip_idx;
    w_dec_valid = dec_valid;
    w_dec_idx   = dec_idx_out;
    w_var_idx   = var_idx_out;
    w_val       = val_out;
    w_all       = all_assigned;
    w_hit       = EW'(r_ptr) + EW'(w_offset);
    w_adv       = EW'(r_ptr) + EW'(SCAN_WIDTH);
    w_cfg       = dec_config[w_hit[VAR_BITS-1:0]];
    w_flip_hit  = r_flip_pend && (w_hit == EW'(r_flip_idx));

    if (bt_valid) begin
      w_state     = IDLE;
      w_dec_valid = 1'b0;
      w_flip_pend = bt_flip;
      w_flip_idx  = bt_dec_idx;
      if (bt_dec_idx >= PW'(NUM_VARS)) begin
        w_ptr = PW'(NUM_VARS);
        w_all = 1'b1;
      end else begin
        w_ptr = bt_dec_idx;
        w_all = 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: if (req && !all_assigned) w_state = SCAN;
        SCAN: begin
          if (w_found) begin
            w_dec_idx   = w_hit[VAR_BITS-1:0];
            w_var_idx   = VAR_BITS'(w_cfg.var_idx);
            w_val       = w_cfg.val ^ w_flip_hit;
            w_dec_valid = 1'b1;
            w_state     = HOLD;
            if (w_flip_hit) w_flip_pend = 1'b0;
          end else if (w_adv >= EW'(NUM_VARS)) begin
            w_ptr   = PW'(NUM_VARS);
            w_all   = 1'b1;
            w_state = IDLE;
          end else begin
            w_ptr = w_adv[PW-1:0];
          end
        end
        HOLD: begin
          if (dec_ack) begin
            w_ptr       = PW'(dec_idx_out) + PW'(1);
            w_dec_valid = 1'b0;
            w_state     = IDLE;
          end
        end
        default: w_state = IDLE;
      endcase
    end
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_flip_pend  <= 1'b0;
      r_flip_idx   <= '0;
      dec_valid    <= 1'b0;
      dec_idx_out  <= '0;
      var_idx_out  <= '0;
      val_out      <= 1'b0;
      all_assigned <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_ptr        <= w_ptr;
      r_flip_pend  <= w_flip_pend;
      r_flip_idx   <= w_flip_idx;
      dec_valid    <= w_dec_valid;
      dec_idx_out  <= w_dec_idx;
      var_idx_out  <= w_var_idx;
      val_out      <= w_val;
      all_assigned <= w_all;
      busy         <= w_busy;
    end
  end

endmodule
